// File: rtl/maxf_pkg.sv
// Shared types for the max finder: state encoding,
// operand count and the lowest-set-index priority helper.
package maxf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_IN = 4;

  function automatic logic [1:0] lowest_idx(
    input logic [NUM_IN-1:0] m
  );
    lowest_idx = 2'd0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/max_finder_ctrl_if.sv
// Start/ready handshake, operands and result bus
// between a requester and the max finder.
interface max_finder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             ready;
  logic             busy;
  logic             done;
  logic [1:0]       max_idx;
  logic [WIDTH-1:0] max_val;

  modport master (
    output start,
    output in0,
    output in1,
    output in2,
    output in3,
    input  ready,
    input  busy,
    input  done,
    input  max_idx,
    input  max_val
  );

  modport slave (
    input  start,
    input  in0,
    input  in1,
    input  in2,
    input  in3,
    output ready,
    output busy,
    output done,
    output max_idx,
    output max_val
  );

endinterface

// File: rtl/single_survivor_check.sv
// Flags a candidate mask with exactly one bit set,
// used to stop the scan once a single operand survives.
module single_survivor_check
  import maxf_pkg::*;
(
  input  logic [NUM_IN-1:0] mask,
  output logic              single
);

  logic [NUM_IN-1:0] mask_m1;

  // Clearing the lowest set bit leaves zero only for a one-hot mask
  always_comb begin
    mask_m1 = mask - 1'b1;
    single  = (mask != '0) && ((mask & mask_m1) == '0);
  end

endmodule

// File: rtl/max_finder_ctrl.sv
// MSB-first bit-serial max of four operands with start/ready/done.
// Define MAXF_EARLY_EXIT_EN to stop the scan once one candidate remains.
module max_finder_ctrl
  import maxf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  max_finder_ctrl_if.slave   bus
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PTR_TOP = PW'(WIDTH - 1);

  state_t            state;
  state_t            state_n;
  logic [WIDTH-1:0]  op [NUM_IN];
  logic [NUM_IN-1:0] mask;
  logic [NUM_IN-1:0] col;
  logic [NUM_IN-1:0] next_mask;
  logic [PW-1:0]     bit_ptr;
  logic              single;
  logic              last_col;
  logic [1:0]        win_idx;
  logic              accept;

`ifdef MAXF_EARLY_EXIT_EN
  single_survivor_check u_ssc (
    .mask   (next_mask),
    .single (single)
  );
`else
  assign single = 1'b0;
`endif

  // Current column of surviving candidates; keep the set if all lose
  always_comb begin
    col = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      col[i] = op[i][bit_ptr] & mask[i];
    end
    next_mask = (col != '0) ? col : mask;
    last_col  = (bit_ptr == '0) || single;
    win_idx   = lowest_idx(next_mask);
    accept    = (state == IDLE) && bus.start;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = SCAN;
      SCAN:    if (last_col) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand capture, candidate mask and column pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      mask    <= '1;
      bit_ptr <= PTR_TOP;
      for (int i = 0; i < NUM_IN; i++) op[i] <= '0;
    end else if (accept) begin
      op[0]   <= bus.in0;
      op[1]   <= bus.in1;
      op[2]   <= bus.in2;
      op[3]   <= bus.in3;
      mask    <= '1;
      bit_ptr <= PTR_TOP;
    end else if (state == SCAN) begin
      mask <= next_mask;
      if (!last_col) bit_ptr <= bit_ptr - 1'b1;
    end
  end

  // Result registers, loaded on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.max_idx <= '0;
      bus.max_val <= '0;
    end else if (state == SCAN && last_col) begin
      bus.max_idx <= win_idx;
      bus.max_val <= op[win_idx];
    end
  end

  // Status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.ready <= (state_n == IDLE);
      bus.busy  <= (state_n != IDLE);
      bus.done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_max_finder_ctrl.sv
// Bench for max_finder_ctrl: vector table, random ops,
// busy-start and mid-scan reset sequences, done scoreboard.
module tb_max_finder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [3:0][W-1:0] v;
    logic [1:0]        idx;
    logic [W-1:0]      val;
    int                k;
  } vec_t;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] val;
    int           at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  max_finder_ctrl_if #(.WIDTH(W)) bus ();

  max_finder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, b, c, d,
                              input logic [1:0] idx,
                              input logic [W-1:0] val, input int k);
    vec_t r;
    r.v[0] = a;
    r.v[1] = b;
    r.v[2] = c;
    r.v[3] = d;
    r.idx  = idx;
    r.val  = val;
    r.k    = k;
    return r;
  endfunction

  function automatic vec_t model(input logic [3:0][W-1:0] v);
    vec_t r;
    logic [3:0] m;
    logic [3:0] c;
    r.v   = v;
    r.idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (v[i] > v[r.idx]) r.idx = 2'(i);
    end
    r.val = v[r.idx];
    r.k   = W;
    m     = 4'hF;
    for (int b = W - 1; b >= 0; b--) begin
      for (int i = 0; i < 4; i++) c[i] = v[i][b] & m[i];
      if (c != 0) m = c;
      if ($countones(m) == 1 && r.k == W) r.k = W - b;
    end
    return r;
  endfunction

  function automatic int lat(input int k_early);
`ifdef MAXF_EARLY_EXIT_EN
    return k_early;
`else
    return (k_early > 0) ? W : W;
`endif
  endfunction

  // Scoreboard: every done pulse must match the oldest pending result
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done at cycle %0d", cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("max_idx", 32'(bus.max_idx), 32'(e.idx));
        chk("max_val", 32'(bus.max_val), 32'(e.val));
        chk("done_cycle", 32'(cnt), 32'(e.at));
        chk("busy_in_done", 32'(bus.busy), 32'd1);
      end
    end
  end

  // The candidate mask must never empty out
  always @(posedge clk) begin
    if (!rst) begin
      assert (dut.mask != 4'b0000)
      else begin
        errors++;
        $display("FAIL mask_zero at cycle %0d", cnt);
      end
    end
  end

  task automatic run_op(input vec_t t, input bit poke);
    int tries;
    exp_t e;
    chk("ready_idle", 32'(bus.ready), 32'd1);
    bus.in0   = t.v[0];
    bus.in1   = t.v[1];
    bus.in2   = t.v[2];
    bus.in3   = t.v[3];
    bus.start = 1'b1;
    e.idx = t.idx;
    e.val = t.val;
    e.at  = cnt + 1 + lat(t.k);
    q.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.in0   = W'($urandom);
    bus.in1   = W'($urandom);
    bus.in2   = W'($urandom);
    bus.in3   = W'($urandom);
    chk("busy_scan", 32'(bus.busy), 32'd1);
    chk("ready_scan", 32'(bus.ready), 32'd0);
    if (poke) begin
      bus.start = 1'b1;
      bus.in3   = '1;
      tick();
      bus.start = 1'b0;
      if (q.size() != 0) chk("ready_poke", 32'(bus.ready), 32'd0);
    end
    tries = 0;
    while (q.size() != 0 && tries < 2 * W + 4) begin
      tick();
      tries++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d want=0", q.size());
      q.delete();
    end
    tick();
    chk("ready_after", 32'(bus.ready), 32'd1);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("done_after", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    logic [3:0][W-1:0] rv;

    tbl[0]  = mk(8'h10, 8'h80, 8'h20, 8'h05, 2'd1, 8'h80, 1);
    tbl[1]  = mk(8'h7F, 8'h7E, 8'h00, 8'h01, 2'd0, 8'h7F, 8);
    tbl[2]  = mk(8'h3C, 8'h3C, 8'h3C, 8'h3C, 2'd0, 8'h3C, 8);
    tbl[3]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8);
    tbl[4]  = mk(8'h01, 8'h02, 8'h04, 8'h08, 2'd3, 8'h08, 5);
    tbl[5]  = mk(8'hFF, 8'h00, 8'h00, 8'hFF, 2'd0, 8'hFF, 8);
    tbl[6]  = mk(8'h40, 8'h41, 8'hC0, 8'hC1, 2'd3, 8'hC1, 8);
    tbl[7]  = mk(8'h00, 8'h00, 8'h00, 8'h01, 2'd3, 8'h01, 8);
    tbl[8]  = mk(8'hAA, 8'h55, 8'hAB, 8'hA9, 2'd2, 8'hAB, 8);
    tbl[9]  = mk(8'h80, 8'h80, 8'h7F, 8'h00, 2'd0, 8'h80, 8);
    tbl[10] = mk(8'h00, 8'hC0, 8'h80, 8'h00, 2'd1, 8'hC0, 2);

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in0   = '0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.in3   = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_idx", 32'(bus.max_idx), 32'd0);
    chk("rst_val", 32'(bus.max_val), 32'd0);

    for (int i = 0; i < 11; i++) run_op(tbl[i], 1'b0);

    run_op(tbl[0], 1'b1);
    run_op(tbl[1], 1'b1);
    run_op(tbl[10], 1'b0);

    bus.in0   = 8'h7F;
    bus.in1   = 8'h7E;
    bus.in2   = 8'h00;
    bus.in3   = 8'h01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_idx", 32'(bus.max_idx), 32'd0);
    chk("mid_rst_val", 32'(bus.max_val), 32'd0);
    chk("mid_rst_mask", 32'(dut.mask), 32'hF);
    repeat (W + 3) tick();
    run_op(tbl[1], 1'b0);

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) begin
        rv[i] = W'($urandom);
        if (n[0]) rv[i][W-1:W-2] = 2'b11;
      end
      r = model(rv);
      run_op(r, n[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
